fan_pwm_ctrl: RTL and testbench

- Parametrised button-driven PWM fan/LED controller; next generation of the fixed 4-step fan LED driver.
- Adds:
  - configurable level count and duty step
  - glitch-free duty update at PWM period boundaries
  - optional soft ramp toward the target duty
  - a force-off input
  - level status outputs
- Sits between the debounced front-panel buttons and the fan motor driver / indicator LED.

---
 rtl/fan_pwm_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_fan_pwm_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_pwm_ctrl.sv
// rtl/fan_pwm_ctrl.sv - button-driven PWM fan/LED controller with level FSM and soft duty ramp
//
// Purpose:
//   Turns two debounced front-panel buttons into a speed level and drives a
//   100-step PWM output. The applied duty cycle only changes on PWM period
//   boundaries, either jumping to the target or ramping 1% at a time.
//
// Parameters:
//   CLK_DIV      clk cycles per PWM tick (>= 1); PWM period = 100 ticks
//   NUM_LEVELS   number of speed levels (2..8), level 0 is off
//   DUTY_STEP    duty percent per level, (NUM_LEVELS-1)*DUTY_STEP <= 100
//   RAMP_PERIODS PWM periods per 1% ramp step, 0 = jump to target
//
// Ports:
//   clk          in   1  system clock
//   reset_n      in   1  asynchronous active-low reset
//   btn          in   1  level-advance request, asynchronous to clk
//   btn_off      in   1  force level 0, asynchronous to clk
//   pwm_out      out  1  registered PWM drive
//   level        out  3  current level, 0..NUM_LEVELS-1
//   level_onehot out  8  one-hot of level, bits >= NUM_LEVELS stay 0
//   duty_cur     out  7  duty percent currently applied (0..100)
//   ramping      out  1  high while duty_cur differs from the target duty

`timescale 1ns/1ps

module fan_pwm_ctrl #(
  parameter int CLK_DIV      = 1000,
  parameter int NUM_LEVELS   = 4,
  parameter int DUTY_STEP    = 30,
  parameter int RAMP_PERIODS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn,
  input  logic       btn_off,
  output logic       pwm_out,
  output logic [2:0] level,
  output logic [7:0] level_onehot,
  output logic [6:0] duty_cur,
  output logic       ramping
);

  localparam int          PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [2:0]  LEVEL_MAX = 3'(NUM_LEVELS - 1);
  localparam logic [6:0]  PWM_LAST  = 7'd99;

  // ---------------------------------------------------------------------------
  // Input synchronisers: two metastability flops plus one history flop each.
  // A rise is reported for exactly one cycle, so a held button never repeats.
  // ---------------------------------------------------------------------------
  logic r_btn_s1;
  logic r_btn_s2;
  logic r_btn_hist;
  logic r_off_s1;
  logic r_off_s2;
  logic r_off_hist;
  logic w_btn_rise;
  logic w_off_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_btn_hist <= 1'b0;
      r_off_s1   <= 1'b0;
      r_off_s2   <= 1'b0;
      r_off_hist <= 1'b0;
    end else begin
      r_btn_s1   <= btn;
      r_btn_s2   <= r_btn_s1;
      r_btn_hist <= r_btn_s2;
      r_off_s1   <= btn_off;
      r_off_s2   <= r_off_s1;
      r_off_hist <= r_off_s2;
    end
  end

  assign w_btn_rise = r_btn_s2 & ~r_btn_hist;
  assign w_off_rise = r_off_s2 & ~r_off_hist;

  // ---------------------------------------------------------------------------
  // Level FSM: the state is the level itself.
  // ---------------------------------------------------------------------------
  logic [2:0] r_level;
  logic [2:0] w_level_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 3'd0;
    end else begin
      r_level <= w_level_nxt;
    end
  end

  // Next-state logic; force-off takes priority over a simultaneous advance
  always_comb begin
    w_level_nxt = r_level;
    if (w_off_rise) begin
      w_level_nxt = 3'd0;
    end else if (w_btn_rise) begin
      if (r_level == LEVEL_MAX) begin
        w_level_nxt = 3'd0;
      end else begin
        w_level_nxt = r_level + 3'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    level_onehot          = 8'd0;
    level_onehot[r_level] = 1'b1;
  end

  assign level = r_level;

  // ---------------------------------------------------------------------------
  // Target duty: kept 10 bits wide so level*DUTY_STEP never truncates even
  // for an out-of-range parameter combination.
  // ---------------------------------------------------------------------------
  logic [9:0] w_target;

  assign w_target = 10'(r_level) * 10'(DUTY_STEP);

  // ---------------------------------------------------------------------------
  // Prescaler and PWM counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic [6:0]    r_pwm_cnt;
  logic          w_tick;
  logic          w_boundary;

  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_boundary = w_tick && (r_pwm_cnt == PWM_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= 7'd0;
    end else if (w_tick) begin
      if (r_pwm_cnt == PWM_LAST) begin
        r_pwm_cnt <= 7'd0;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + 7'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Duty update. Changing duty only when the counter wraps keeps every PWM
  // period internally consistent: no runt or stretched pulses.
  // ---------------------------------------------------------------------------
  logic [6:0] r_duty;
  logic [9:0] w_duty_ext;

  assign w_duty_ext = {3'b000, r_duty};

  generate
    if (RAMP_PERIODS == 0) begin : g_jump
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_duty <= 7'd0;
        end else if (w_boundary) begin
          r_duty <= w_target[6:0];
        end
      end
    end else begin : g_ramp
      localparam int RW = $clog2(RAMP_PERIODS + 1);

      logic [RW-1:0] r_ramp_cnt;
      logic          w_ramp_step;

      // Step on the RAMP_PERIODS-th boundary since the last step. The ramp
      // always moves from the present duty, so a new target simply redirects it.
      assign w_ramp_step = (r_ramp_cnt == RW'(RAMP_PERIODS - 1));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_ramp_cnt <= '0;
          r_duty     <= 7'd0;
        end else if (w_boundary) begin
          if (w_ramp_step) begin
            r_ramp_cnt <= '0;
            if (w_duty_ext < w_target) begin
              r_duty <= r_duty + 7'd1;
            end else if (w_duty_ext > w_target) begin
              r_duty <= r_duty - 7'd1;
            end
          end else begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign duty_cur = r_duty;
  assign ramping  = (w_duty_ext != w_target);

  // ---------------------------------------------------------------------------
  // PWM output. Counter runs 0..99, so duty 100 holds high across the wrap
  // and duty 0 holds low.
  // ---------------------------------------------------------------------------
  logic r_pwm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (r_pwm_cnt < r_duty);
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// tb/tb_fan_pwm_ctrl.sv - scoreboard bench for fan_pwm_ctrl, two parameter sets
`timescale 1ns/1ps

module tb_fan_pwm_ctrl;

  // Instance 0: CLK_DIV=2, 4 levels x 30%, jump. Instance 1: CLK_DIV=1, 3 levels x 50%, ramp 1.
  function automatic int cd_of(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int nl_of(int i); return (i == 0) ? 4 : 3; endfunction
  function automatic int st_of(int i); return (i == 0) ? 30 : 50; endfunction
  function automatic int rp_of(int i); return (i == 0) ? 0 : 1; endfunction

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic btn = 1'b0;
  logic btn_off = 1'b0;
  logic stop_req = 1'b0;
  logic timeout_hit = 1'b0;

  always #5 clk = ~clk;

  logic       pwm_o  [2];
  logic [2:0] lvl_o  [2];
  logic [7:0] oh_o   [2];
  logic [6:0] duty_o [2];
  logic       ramp_o [2];

  fan_pwm_ctrl #(.CLK_DIV(2), .NUM_LEVELS(4), .DUTY_STEP(30), .RAMP_PERIODS(0)) u_a (
    .clk(clk), .reset_n(reset_n), .btn(btn), .btn_off(btn_off),
    .pwm_out(pwm_o[0]), .level(lvl_o[0]), .level_onehot(oh_o[0]),
    .duty_cur(duty_o[0]), .ramping(ramp_o[0]));

  fan_pwm_ctrl #(.CLK_DIV(1), .NUM_LEVELS(3), .DUTY_STEP(50), .RAMP_PERIODS(1)) u_b (
    .clk(clk), .reset_n(reset_n), .btn(btn), .btn_off(btn_off),
    .pwm_out(pwm_o[1]), .level(lvl_o[1]), .level_onehot(oh_o[1]),
    .duty_cur(duty_o[1]), .ramping(ramp_o[1]));

  typedef struct {
    int val;
    int k;
  } exp_t;

  exp_t lq[2][$];
  exp_t dq[2][$];

  // Reference model state: k counts clk edges since reset release
  int m_k[2];
  int m_lvl[2];
  int m_duty[2];
  int m_bnd[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp_v);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_step(input int i, input bit ev_b, input bit ev_o);
    int   p;
    int   tgt;
    int   nd;
    int   nl;
    exp_t e;
    m_k[i]++;
    p = 100 * cd_of(i);
    // Period boundary: every 100*CLK_DIV edges; uses the level held before this edge
    if (m_k[i] % p == 0) begin
      tgt = m_lvl[i] * st_of(i);
      nd  = m_duty[i];
      if (rp_of(i) == 0) begin
        nd = tgt;
      end else begin
        m_bnd[i]++;
        if (m_bnd[i] % rp_of(i) == 0) nd = nd + ((tgt > nd) ? 1 : (tgt < nd) ? -1 : 0);
      end
      if (nd != m_duty[i]) begin
        e.val = nd;
        e.k   = m_k[i];
        dq[i].push_back(e);
        m_duty[i] = nd;
      end
    end
    nl = ev_o ? 0 : (ev_b ? (m_lvl[i] + 1) % nl_of(i) : m_lvl[i]);
    if (nl != m_lvl[i]) begin
      e.val = nl;
      e.k   = m_k[i];
      lq[i].push_back(e);
      m_lvl[i] = nl;
    end
  endtask

  // Model: a press takes effect on the 3rd consecutive edge that sees the raw input high
  initial begin
    int run_b;
    int run_o;
    run_b = 0;
    run_o = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        run_b = 0;
        run_o = 0;
        for (int i = 0; i < 2; i++) begin
          m_k[i] = 0; m_lvl[i] = 0; m_duty[i] = 0; m_bnd[i] = 0;
          lq[i].delete();
          dq[i].delete();
        end
      end else begin
        run_b = btn ? run_b + 1 : 0;
        run_o = btn_off ? run_o + 1 : 0;
        for (int i = 0; i < 2; i++) model_step(i, run_b == 3, run_o == 3);
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a change, checks PWM per period
  initial begin
    int       seen_lvl [2];
    int       seen_duty[2];
    int       highs    [2];
    int       mis      [2];
    int       win      [2];
    bit       in_reset;
    bit       exp_s;
    int       p;
    exp_t     e;
    logic [7:0] eoh;
    in_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seen_lvl[i] = 0; seen_duty[i] = 0; highs[i] = 0; mis[i] = 0; win[i] = 0;
    end
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        if (!in_reset) begin
          in_reset = 1'b1;
          #1;
          for (int i = 0; i < 2; i++) begin
            chk(pwm_o[i] == 1'b0, "rst_pwm", int'(pwm_o[i]), 0);
            chk(lvl_o[i] == 3'd0, "rst_level", int'(lvl_o[i]), 0);
            chk(oh_o[i] == 8'd1, "rst_onehot", int'(oh_o[i]), 1);
            chk(duty_o[i] == 7'd0, "rst_duty", int'(duty_o[i]), 0);
            chk(ramp_o[i] == 1'b0, "rst_ramping", int'(ramp_o[i]), 0);
            seen_lvl[i] = 0; seen_duty[i] = 0; highs[i] = 0; mis[i] = 0; win[i] = 0;
          end
        end
      end else begin
        in_reset = 1'b0;
        if (stop_req) begin
          for (int i = 0; i < 2; i++) begin
            chk(lq[i].size() == 0, "level_changes_missing", lq[i].size(), 0);
            chk(dq[i].size() == 0, "duty_changes_missing", dq[i].size(), 0);
          end
          chk(!timeout_hit, "wait_pwm_high_timeout", int'(timeout_hit), 0);
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $finish;
        end
        for (int i = 0; i < 2; i++) begin
          if (m_k[i] > 0) begin
            p = 100 * cd_of(i);
            if (int'(lvl_o[i]) != seen_lvl[i]) begin
              if (lq[i].size() == 0) begin
                chk(1'b0, "level_unexpected", int'(lvl_o[i]), seen_lvl[i]);
              end else begin
                e = lq[i].pop_front();
                chk(int'(lvl_o[i]) == e.val, "level_value", int'(lvl_o[i]), e.val);
                chk(m_k[i] == e.k, "level_edge", m_k[i], e.k);
                eoh = 8'd1 << e.val;
                chk(oh_o[i] == eoh, "level_onehot", int'(oh_o[i]), int'(eoh));
              end
              seen_lvl[i] = int'(lvl_o[i]);
            end
            if (int'(duty_o[i]) != seen_duty[i]) begin
              if (dq[i].size() == 0) begin
                chk(1'b0, "duty_unexpected", int'(duty_o[i]), seen_duty[i]);
              end else begin
                e = dq[i].pop_front();
                chk(int'(duty_o[i]) == e.val, "duty_value", int'(duty_o[i]), e.val);
                chk(m_k[i] == e.k, "duty_edge", m_k[i], e.k);
              end
              seen_duty[i] = int'(duty_o[i]);
            end
            // Registered output reflects the counter position before this edge
            exp_s = (((m_k[i] - 1) / cd_of(i)) % 100) < win[i];
            if (pwm_o[i] !== exp_s) mis[i]++;
            if (pwm_o[i] === 1'b1) highs[i]++;
            if (m_k[i] % p == 0) begin
              chk(mis[i] == 0, "pwm_pattern_mismatched_samples", mis[i], 0);
              chk(highs[i] == win[i] * cd_of(i), "pwm_high_cycles", highs[i], win[i] * cd_of(i));
              chk(ramp_o[i] == (m_duty[i] != m_lvl[i] * st_of(i)), "ramping",
                  int'(ramp_o[i]), int'(m_duty[i] != m_lvl[i] * st_of(i)));
              win[i]   = m_duty[i];
              highs[i] = 0;
              mis[i]   = 0;
            end
          end
        end
      end
    end
  end

  // Stimulus: inputs change 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit b, input bit o, input int hold, input int gap);
    btn     = b;
    btn_off = o;
    step(hold);
    btn     = 1'b0;
    btn_off = 1'b0;
    step(gap);
  endtask

  initial begin
    int r;
    #2 reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(5);
    press(1'b1, 1'b0, 4, 600);
    repeat (4) press(1'b1, 1'b0, 5, 450);
    press(1'b1, 1'b0, 5, 300);
    press(1'b1, 1'b1, 5, 300);
    press(1'b1, 1'b0, 1000, 300);
    press(1'b0, 1'b1, 5, 300);
    press(1'b1, 1'b0, 5, 300);
    press(1'b1, 1'b0, 5, 11000);
    press(1'b0, 1'b1, 5, 3000);
    for (int t = 0; t < 300 && pwm_o[1] !== 1'b1; t++) step(1);
    if (pwm_o[1] !== 1'b1) timeout_hit = 1'b1;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    repeat (40) begin
      r = $urandom_range(0, 9);
      press((r < 6) || (r >= 8), r >= 6, $urandom_range(3, 8), $urandom_range(3, 500));
    end
    step(400);
    stop_req = 1'b1;
    #1000;
    $display("FAIL monitor_stalled: summary not reached, expected finish");
    $fatal(1);
  end

endmodule
